// File: rtl/uart_echo_fifo.sv
// Buffered UART echo engine: deserialises frames from rx_i, queues good bytes
// in a small FIFO and reserialises them on tx_o in arrival order. Also keeps
// sticky error flags and drives two stretched activity LEDs.
module uart_echo_fifo #(
  parameter int CLOCKS_PER_BAUD = 104,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int FIFO_DEPTH      = 16,
  parameter int LED_CYCLES      = 600000
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          rx_i,
  output logic                          tx_o,
  input  logic                          tx_hold_i,
  input  logic                          clear_errors_i,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic                          overflow_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          rx_led_o,
  output logic                          byte_led_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam int BW = $clog2(DATA_BITS);
  localparam int LW = $clog2(LED_CYCLES + 1);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] LED_LOAD   = LW'(LED_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam bit            HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  // Parity bit that makes data^p even (PARITY=1) or odd (PARITY=2) weight.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------- RX ----
  logic rx_meta, rx_sync;

  // Two-flop synchroniser; presets to idle-high so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end
  end

  rx_state_t            rx_state, rx_state_next;
  logic [CW-1:0]        rx_cnt, rx_cnt_next;
  logic [BW-1:0]        rx_bit, rx_bit_next;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_next;
  logic                 rx_par, rx_par_next;
  logic                 push_req, push_req_next;
  logic                 frame_evt, parity_evt;

  // RX next-state: mid-bit sampling, frame checks, push request after a good stop.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_next   = rx_cnt;
    rx_bit_next   = rx_bit;
    rx_shift_next = rx_shift;
    rx_par_next   = rx_par;
    push_req_next = 1'b0;
    frame_evt     = 1'b0;
    parity_evt    = 1'b0;
    unique case (rx_state)
      RX_IDLE: if (!rx_sync) begin
        rx_state_next = RX_START;
        rx_cnt_next   = '0;
      end
      RX_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_next   = '0;
        rx_bit_next   = '0;
        rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
      end else rx_cnt_next = rx_cnt + 1'b1;
      RX_DATA: if (rx_cnt == BAUD_LAST) begin
        rx_cnt_next   = '0;
        rx_shift_next = {rx_sync, rx_shift[DATA_BITS-1:1]};
        if (rx_bit == BIT_LAST) rx_state_next = HAS_PARITY ? RX_PARITY : RX_STOP;
        else                    rx_bit_next   = rx_bit + 1'b1;
      end else rx_cnt_next = rx_cnt + 1'b1;
      RX_PARITY: if (rx_cnt == BAUD_LAST) begin
        rx_cnt_next   = '0;
        rx_par_next   = rx_sync;
        rx_state_next = RX_STOP;
      end else rx_cnt_next = rx_cnt + 1'b1;
      RX_STOP: if (rx_cnt == BAUD_LAST) begin
        rx_cnt_next = '0;
        if (!rx_sync) begin
          frame_evt     = 1'b1;
          rx_state_next = RX_WAIT_HIGH;
        end else if (HAS_PARITY && (rx_par != parity_of(rx_shift))) begin
          parity_evt    = 1'b1;
          rx_state_next = RX_IDLE;
        end else begin
          push_req_next = 1'b1;
          rx_state_next = RX_IDLE;
        end
      end else rx_cnt_next = rx_cnt + 1'b1;
      RX_WAIT_HIGH: if (rx_sync) rx_state_next = RX_IDLE;
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
      push_req <= 1'b0;
    end else begin
      rx_state <= rx_state_next;
      rx_cnt   <= rx_cnt_next;
      rx_bit   <= rx_bit_next;
      rx_shift <= rx_shift_next;
      rx_par   <= rx_par_next;
      push_req <= push_req_next;
    end
  end

  // -------------------------------------------------------------- FIFO ----
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 pop, push_ok, overflow_evt, full, empty;

  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign push_ok      = push_req && (!full || pop);
  assign overflow_evt = push_req && !push_ok;
  assign fill_o       = count;

  // Storage array write port.
  // NOTE: the data array has no reset; pointers and count alone define validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= rx_shift;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX ----
  tx_state_t            tx_state, tx_state_next;
  logic [CW-1:0]        tx_cnt, tx_cnt_next;
  logic [BW-1:0]        tx_bit, tx_bit_next;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_next;
  logic                 tx_par, tx_par_next;
  logic                 tx_line_next, can_start;

  assign can_start = !empty && !tx_hold_i;

  // TX next-state: pop on frame start, chain frames back-to-back after stop.
  always_comb begin
    tx_state_next = tx_state;
    tx_cnt_next   = tx_cnt;
    tx_bit_next   = tx_bit;
    tx_shift_next = tx_shift;
    tx_par_next   = tx_par;
    pop           = 1'b0;
    unique case (tx_state)
      TX_IDLE: if (can_start) begin
        pop           = 1'b1;
        tx_shift_next = mem[rd_ptr];
        tx_par_next   = parity_of(mem[rd_ptr]);
        tx_cnt_next   = '0;
        tx_state_next = TX_START;
      end
      TX_START: if (tx_cnt == BAUD_LAST) begin
        tx_cnt_next   = '0;
        tx_bit_next   = '0;
        tx_state_next = TX_DATA;
      end else tx_cnt_next = tx_cnt + 1'b1;
      TX_DATA: if (tx_cnt == BAUD_LAST) begin
        tx_cnt_next = '0;
        if (tx_bit == BIT_LAST) tx_state_next = HAS_PARITY ? TX_PARITY : TX_STOP;
        else begin
          tx_bit_next   = tx_bit + 1'b1;
          tx_shift_next = tx_shift >> 1;
        end
      end else tx_cnt_next = tx_cnt + 1'b1;
      TX_PARITY: if (tx_cnt == BAUD_LAST) begin
        tx_cnt_next   = '0;
        tx_state_next = TX_STOP;
      end else tx_cnt_next = tx_cnt + 1'b1;
      TX_STOP: if (tx_cnt == BAUD_LAST) begin
        tx_cnt_next = '0;
        if (can_start) begin
          pop           = 1'b1;
          tx_shift_next = mem[rd_ptr];
          tx_par_next   = parity_of(mem[rd_ptr]);
          tx_state_next = TX_START;
        end else tx_state_next = TX_IDLE;
      end else tx_cnt_next = tx_cnt + 1'b1;
      default: tx_state_next = TX_IDLE;
    endcase
    unique case (tx_state_next)
      TX_START:  tx_line_next = 1'b0;
      TX_DATA:   tx_line_next = tx_shift_next[0];
      TX_PARITY: tx_line_next = tx_par_next;
      default:   tx_line_next = 1'b1;
    endcase
  end

  // TX state register; tx_o is registered so the pin never glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_o     <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx_cnt   <= tx_cnt_next;
      tx_bit   <= tx_bit_next;
      tx_shift <= tx_shift_next;
      tx_par   <= tx_par_next;
      tx_o     <= tx_line_next;
    end
  end

  // ------------------------------------------------------ flags / LEDs ----
  // Sticky flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_o   <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      overflow_o   <= overflow_evt | (overflow_o   & ~clear_errors_i);
      frame_err_o  <= frame_evt    | (frame_err_o  & ~clear_errors_i);
      parity_err_o <= parity_evt   | (parity_err_o & ~clear_errors_i);
    end
  end

  logic [LW-1:0] rx_led_cnt, byte_led_cnt;
  logic          rx_trig, byte_trig;

  assign rx_trig    = !rx_sync;
  assign byte_trig  = push_ok;
  assign rx_led_o   = rx_trig   || (rx_led_cnt   != '0);
  assign byte_led_o = byte_trig || (byte_led_cnt != '0);

  // Retriggerable stretch counters for the activity LEDs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_led_cnt   <= '0;
      byte_led_cnt <= '0;
    end else begin
      if (rx_trig)                 rx_led_cnt   <= LED_LOAD;
      else if (rx_led_cnt != '0)   rx_led_cnt   <= rx_led_cnt - 1'b1;
      if (byte_trig)               byte_led_cnt <= LED_LOAD;
      else if (byte_led_cnt != '0) byte_led_cnt <= byte_led_cnt - 1'b1;
    end
  end

endmodule
